trap_commit: RTL and testbench
==============================

Name: trap_commit

Overview:
- Consumes the per-instruction exception report from the trap detection unit (`trap_en`, `trap_cause`, `trap_val`) and the `mret`/`sret` requests from decode.
- Sequences architectural trap entry and exit:
  - pipeline flush handshake;
  - privilege/delegation decision;
  - update of the epc/cause/tval and mstatus trap fields;
  - PC redirect handshake to fetch.
- Sits between the execute-stage trap detection and the CSR file. It owns the current privilege level (`prv_cur`) fed back to trap detection.

Parameters:
- XLEN, 32, data/address width.
- RST_PRV, 2'b11, privilege level after reset (`PRV_M`).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- trap_en  in  1  exception report valid for the committing instruction.
- trap_cause  in  XLEN  exception code; MSB always 0 (exceptions only).
- trap_val  in  XLEN  tval payload.
- trap_epc  in  XLEN  PC of the faulting or xret instruction.
- mret  in  1  mret request; already privilege-checked upstream.
- sret  in  1  sret request; already privilege-checked upstream.
- medeleg  in  XLEN  exception delegation mask.
- mtvec  in  XLEN  M trap vector.
- stvec  in  XLEN  S trap vector.
- csr_we  in  1  software CSR write strobe.
- csr_waddr  in  12  CSR address: mepc 0x341, mcause 0x342, mtval 0x343, sepc 0x141, scause 0x142, stval 0x143, mstatus 0x300.
- csr_wdata  in  XLEN  software write data.
- busy  out  1  sequence in progress; upstream must hold new reports.
- flush_req  out  1  request pipeline flush.
- flush_ack  in  1  pipeline drained.
- redir_valid  out  1  PC redirect valid.
- redir_pc  out  XLEN  redirect target.
- redir_ready  in  1  fetch accepted redirect.
- prv_cur  out  2  current privilege.
- mepc, mcause, mtval, sepc, scause, stval  out  XLEN  trap CSRs.
- mstatus_tf  out  XLEN  mstatus with MIE[3], SIE[1], MPIE[7], SPIE[5], SPP[8], MPP[12:11] populated; all other bits 0.

Behaviour:
- Reset values (sync `rst`):
  - State is IDLE.
  - `prv_cur` = RST_PRV.
  - All CSR outputs are 0, except MPP = 2'b11.
  - `busy`, `flush_req` and `redir_valid` are 0.
  - `redir_pc` is 0.
- States: IDLE, FLUSH, COMMIT, REDIR.
- IDLE:
  - On `trap_en`, `mret` or `sret`: latch the event kind, cause, val and epc; go to FLUSH; `busy` = 1 from the next cycle.
  - If `trap_en` is asserted together with `mret`/`sret`, the trap wins and the xret is dropped.
  - If `mret` and `sret` are both asserted, `mret` wins.
- FLUSH:
  - `flush_req` = 1.
  - Stay in FLUSH until `flush_ack`. On `flush_ack`, go to COMMIT; `flush_ack` in the same cycle flush_req first rises is legal.
- COMMIT (exactly one cycle), by event kind:
  - **Trap, target selection.** Target is S if `prv_cur` != M and `medeleg[cause[4:0]]` = 1; otherwise M.
  - **Trap to M:**
    - mepc = {epc[XLEN-1:1],1'b0}; mcause = cause; mtval = val.
    - MPIE = MIE; MIE = 0; MPP = `prv_cur`; `prv_cur` = M.
    - `redir_pc` = {mtvec[XLEN-1:2],2'b00}.
  - **Trap to S:**
    - sepc, scause and stval are written the same way.
    - SPIE = SIE; SIE = 0; SPP = `prv_cur`[0]; `prv_cur` = S.
    - `redir_pc` = {stvec[XLEN-1:2],2'b00}.
  - **mret:** `redir_pc` = mepc; `prv_cur` = MPP; MIE = MPIE; MPIE = 1; MPP = U.
  - **sret:** `redir_pc` = sepc; `prv_cur` = {1'b0,SPP}; SIE = SPIE; SPIE = 1; SPP = 0.
  - Vectored tvec mode (bits[1:0] = 1) is treated as direct for exceptions.
- REDIR:
  - `redir_valid` = 1; `redir_pc` is held stable.
  - On `redir_ready`, go to IDLE; `busy` drops the following cycle.
- Minimum latency from event to `redir_valid`: 3 cycles (`flush_ack` same cycle as first `flush_req`).
- Software CSR writes:
  - Applied only in IDLE; ignored while `busy`.
  - A write and a trap arriving in the same IDLE cycle: the write is applied, then COMMIT overwrites.
  - mepc/sepc writes clear bit 0.
  - mstatus writes touch only the trap-field bits. An MPP write of 2'b10 stores 2'b00 (WARL).
- Events in any state other than IDLE are ignored; upstream is held off by `busy`.
- Reset in any state aborts the sequence immediately: no partial CSR update, and `redir_valid` drops.

Decomposition:
- Shared package `cpu_pkg` (or `cpu_define.h`) holds:
  - `PRV_U`/`PRV_S`/`PRV_M` constants;
  - the CSR address constants;
  - the mstatus bit-position constants;
  - a `trap_evt_e` enum (NONE, TRAP, MRET, SRET);
  - a `trap_st_e` state enum.
- One natural sub-module, `trap_csr_regs`: the CSR register bank with its software write port and the COMMIT update port. The FSM stays in `trap_commit`.

Test Plan:
- Exception from U, no delegation:
  - Stimulus: `prv_cur` = U, `trap_en`, cause = 2, val = 0x00000013, epc = 0x80000104, mtvec = 0x80000201, `flush_ack` after 2 cycles.
  - Response: mepc = 0x80000104, mcause = 2, mtval = 0x13, MPP = 0, `prv_cur` = 3, `redir_pc` = 0x80000200.
- Delegated ecall from U:
  - Stimulus: medeleg = 0x100, cause = 8, stvec = 0x80400000.
  - Response: scause = 8, SPP = 0, SIE = 0 with SPIE = old SIE, `prv_cur` = 1, `redir_pc` = 0x80400000; M CSRs unchanged.
- mret with MPP = 1, MPIE = 1:
  - Response: `redir_pc` = mepc, `prv_cur` = 1, MIE = 1, MPP = 0.
- `trap_en` and `mret` in the same cycle:
  - Response: trap path taken; mcause updated.
- Redirect backpressure and ignored events:
  - Stimulus: `redir_ready` held low 5 cycles; a second `trap_en` pulsed meanwhile.
  - Response: `redir_pc` stable, second event ignored, exactly one CSR update.
- Reset mid-sequence:
  - Stimulus: `rst` asserted in FLUSH.
  - Response: next cycle IDLE, `prv_cur` = 3, `flush_req` = 0, CSRs at reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Privilege levels, trap CSR addresses, mstatus bit positions and
//            the trap sequencer enums shared by the trap commit block.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_S = 2'b01;
  localparam logic [1:0] PRV_M = 2'b11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;

  localparam int MSTATUS_SIE    = 1;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_SPIE   = 5;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_SPP    = 8;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_TRAP = 2'd1,
    EVT_MRET = 2'd2,
    EVT_SRET = 2'd3
  } trap_evt_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_REDIR  = 2'd3
  } trap_st_e;

endpackage
`default_nettype wire

// File: rtl/trap_csr_regs.sv
`default_nettype none
// ============================================================================
// Module   : trap_csr_regs
// Brief    : Trap CSR bank (epc/cause/tval, mstatus trap fields) with a
//            software write port and a trap/xret commit update port.
// Revision : 1.0 - initial release
// ============================================================================
module trap_csr_regs
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_sw_we,
  input  logic [11:0]     i_sw_addr,
  input  logic [XLEN-1:0] i_sw_wdata,
  input  logic            i_cm_en,
  input  trap_evt_e       i_cm_evt,
  input  logic            i_cm_to_s,
  input  logic [1:0]      i_cm_prv,
  input  logic [XLEN-1:0] i_cm_cause,
  input  logic [XLEN-1:0] i_cm_val,
  input  logic [XLEN-1:0] i_cm_epc,
  output logic [XLEN-1:0] o_mepc,
  output logic [XLEN-1:0] o_mcause,
  output logic [XLEN-1:0] o_mtval,
  output logic [XLEN-1:0] o_sepc,
  output logic [XLEN-1:0] o_scause,
  output logic [XLEN-1:0] o_stval,
  output logic [XLEN-1:0] o_mstatus_tf,
  output logic [1:0]      o_mpp,
  output logic            o_spp
);

  logic       r_mie, r_sie, r_mpie, r_spie;
  logic [1:0] w_mpp_wr;
  logic       w_unused_epc0;

  assign w_unused_epc0 = i_cm_epc[0];

  // MPP is WARL: the reserved encoding 2'b10 collapses to U
  assign w_mpp_wr = (i_sw_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == 2'b10) ?
                    PRV_U : i_sw_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO];

  always_ff @(posedge clk) begin
    if (rst) begin
      o_mepc   <= '0;
      o_mcause <= '0;
      o_mtval  <= '0;
      o_sepc   <= '0;
      o_scause <= '0;
      o_stval  <= '0;
      r_mie    <= 1'b0;
      r_sie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_spie   <= 1'b0;
      o_spp    <= 1'b0;
      o_mpp    <= PRV_M;
    end else if (i_cm_en) begin
      case (i_cm_evt)
        EVT_TRAP: begin
          if (i_cm_to_s) begin
            o_sepc   <= {i_cm_epc[XLEN-1:1], 1'b0};
            o_scause <= i_cm_cause;
            o_stval  <= i_cm_val;
            r_spie   <= r_sie;
            r_sie    <= 1'b0;
            o_spp    <= i_cm_prv[0];
          end else begin
            o_mepc   <= {i_cm_epc[XLEN-1:1], 1'b0};
            o_mcause <= i_cm_cause;
            o_mtval  <= i_cm_val;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
            o_mpp    <= i_cm_prv;
          end
        end
        EVT_MRET: begin
          r_mie  <= r_mpie;
          r_mpie <= 1'b1;
          o_mpp  <= PRV_U;
        end
        EVT_SRET: begin
          r_sie  <= r_spie;
          r_spie <= 1'b1;
          o_spp  <= 1'b0;
        end
        default: ;
      endcase
    end else if (i_sw_we) begin
      case (i_sw_addr)
        CSR_MEPC:   o_mepc   <= {i_sw_wdata[XLEN-1:1], 1'b0};
        CSR_MCAUSE: o_mcause <= i_sw_wdata;
        CSR_MTVAL:  o_mtval  <= i_sw_wdata;
        CSR_SEPC:   o_sepc   <= {i_sw_wdata[XLEN-1:1], 1'b0};
        CSR_SCAUSE: o_scause <= i_sw_wdata;
        CSR_STVAL:  o_stval  <= i_sw_wdata;
        CSR_MSTATUS: begin
          r_mie  <= i_sw_wdata[MSTATUS_MIE];
          r_sie  <= i_sw_wdata[MSTATUS_SIE];
          r_mpie <= i_sw_wdata[MSTATUS_MPIE];
          r_spie <= i_sw_wdata[MSTATUS_SPIE];
          o_spp  <= i_sw_wdata[MSTATUS_SPP];
          o_mpp  <= w_mpp_wr;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_mstatus_tf = '0;
    o_mstatus_tf[MSTATUS_MIE]  = r_mie;
    o_mstatus_tf[MSTATUS_SIE]  = r_sie;
    o_mstatus_tf[MSTATUS_MPIE] = r_mpie;
    o_mstatus_tf[MSTATUS_SPIE] = r_spie;
    o_mstatus_tf[MSTATUS_SPP]  = o_spp;
    o_mstatus_tf[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = o_mpp;
  end

endmodule
`default_nettype wire

// File: rtl/trap_commit.sv
`default_nettype none
// ============================================================================
// Module   : trap_commit
// Brief    : Sequences trap entry and mret/sret exit: pipeline flush,
//            delegation decision, CSR commit and PC redirect to fetch.
// Revision : 1.0 - initial release
// ============================================================================
module trap_commit
  import cpu_pkg::*;
#(
  parameter int         XLEN    = 32,
  parameter logic [1:0] RST_PRV = 2'b11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_val,
  input  logic [XLEN-1:0] trap_epc,
  input  logic            mret,
  input  logic            sret,
  input  logic [XLEN-1:0] medeleg,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  input  logic            csr_we,
  input  logic [11:0]     csr_waddr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic            busy,
  output logic            flush_req,
  input  logic            flush_ack,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  input  logic            redir_ready,
  output logic [1:0]      prv_cur,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval,
  output logic [XLEN-1:0] sepc,
  output logic [XLEN-1:0] scause,
  output logic [XLEN-1:0] stval,
  output logic [XLEN-1:0] mstatus_tf
);

  trap_st_e        r_state;
  trap_evt_e       r_evt;
  trap_evt_e       w_evt;
  logic [XLEN-1:0] r_cause, r_val, r_epc;
  logic            w_to_s;
  logic [1:0]      w_mpp;
  logic            w_spp;
  logic            w_unused_tvec;

  assign w_unused_tvec = ^{mtvec[1:0], stvec[1:0]};

  // Trap beats any xret; mret beats sret
  always_comb begin
    w_evt = EVT_NONE;
    if (trap_en)   w_evt = EVT_TRAP;
    else if (mret) w_evt = EVT_MRET;
    else if (sret) w_evt = EVT_SRET;
  end

  assign w_to_s = (prv_cur != PRV_M) && medeleg[r_cause[4:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_evt       <= EVT_NONE;
      r_cause     <= '0;
      r_val       <= '0;
      r_epc       <= '0;
      busy        <= 1'b0;
      flush_req   <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      prv_cur     <= RST_PRV;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_evt != EVT_NONE) begin
            r_evt     <= w_evt;
            r_cause   <= trap_cause;
            r_val     <= trap_val;
            r_epc     <= trap_epc;
            busy      <= 1'b1;
            flush_req <= 1'b1;
            r_state   <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_ack) begin
            flush_req <= 1'b0;
            r_state   <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          case (r_evt)
            EVT_TRAP: begin
              if (w_to_s) begin
                redir_pc <= {stvec[XLEN-1:2], 2'b00};
                prv_cur  <= PRV_S;
              end else begin
                redir_pc <= {mtvec[XLEN-1:2], 2'b00};
                prv_cur  <= PRV_M;
              end
            end
            EVT_MRET: begin
              redir_pc <= mepc;
              prv_cur  <= w_mpp;
            end
            EVT_SRET: begin
              redir_pc <= sepc;
              prv_cur  <= {1'b0, w_spp};
            end
            default: ;
          endcase
          redir_valid <= 1'b1;
          r_state     <= ST_REDIR;
        end
        ST_REDIR: begin
          if (redir_ready) begin
            redir_valid <= 1'b0;
            busy        <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  trap_csr_regs #(
    .XLEN (XLEN)
  ) u_csr_regs (
    .clk          (clk),
    .rst          (rst),
    .i_sw_we      (csr_we && (r_state == ST_IDLE)),
    .i_sw_addr    (csr_waddr),
    .i_sw_wdata   (csr_wdata),
    .i_cm_en      (r_state == ST_COMMIT),
    .i_cm_evt     (r_evt),
    .i_cm_to_s    (w_to_s),
    .i_cm_prv     (prv_cur),
    .i_cm_cause   (r_cause),
    .i_cm_val     (r_val),
    .i_cm_epc     (r_epc),
    .o_mepc       (mepc),
    .o_mcause     (mcause),
    .o_mtval      (mtval),
    .o_sepc       (sepc),
    .o_scause     (scause),
    .o_stval      (stval),
    .o_mstatus_tf (mstatus_tf),
    .o_mpp        (w_mpp),
    .o_spp        (w_spp)
  );

endmodule
`default_nettype wire

// File: tb/tb_trap_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_commit
// Brief    : Self-checking bench for trap_commit against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_commit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            trap_en, mret, sret, csr_we, flush_ack, redir_ready;
  logic [XLEN-1:0] trap_cause, trap_val, trap_epc, medeleg, mtvec, stvec, csr_wdata;
  logic [11:0]     csr_waddr;
  logic            busy, flush_req, redir_valid;
  logic [XLEN-1:0] redir_pc, mepc, mcause, mtval, sepc, scause, stval, mstatus_tf;
  logic [1:0]      prv_cur;

  always #5 clk = ~clk;

  trap_commit #(.XLEN(XLEN), .RST_PRV(2'b11)) dut (
    .clk(clk), .rst(rst), .trap_en(trap_en), .trap_cause(trap_cause),
    .trap_val(trap_val), .trap_epc(trap_epc), .mret(mret), .sret(sret),
    .medeleg(medeleg), .mtvec(mtvec), .stvec(stvec), .csr_we(csr_we),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .busy(busy),
    .flush_req(flush_req), .flush_ack(flush_ack), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .redir_ready(redir_ready), .prv_cur(prv_cur),
    .mepc(mepc), .mcause(mcause), .mtval(mtval), .sepc(sepc),
    .scause(scause), .stval(stval), .mstatus_tf(mstatus_tf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural reference state
  logic [1:0]  m_prv, m_mpp;
  logic [31:0] m_mepc, m_mcause, m_mtval, m_sepc, m_scause, m_stval;
  logic        m_mie, m_sie, m_mpie, m_spie, m_spp;

  logic [11:0] addrs [8] = '{12'h300, 12'h341, 12'h342, 12'h343,
                             12'h141, 12'h142, 12'h143, 12'h305};

  task automatic model_reset();
    m_prv = 2'd3; m_mpp = 2'd3;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_sepc = 0; m_scause = 0; m_stval = 0;
    m_mie = 0; m_sie = 0; m_mpie = 0; m_spie = 0; m_spp = 0;
  endtask

  function automatic logic [31:0] exp_mstatus();
    logic [31:0] v;
    v = '0;
    v[3] = m_mie; v[1] = m_sie; v[7] = m_mpie; v[5] = m_spie; v[8] = m_spp;
    v[12:11] = m_mpp;
    return v;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h341: m_mepc   = d & ~32'd1;
      12'h342: m_mcause = d;
      12'h343: m_mtval  = d;
      12'h141: m_sepc   = d & ~32'd1;
      12'h142: m_scause = d;
      12'h143: m_stval  = d;
      12'h300: begin
        m_mie = d[3]; m_sie = d[1]; m_mpie = d[7]; m_spie = d[5]; m_spp = d[8];
        m_mpp = (d[12:11] == 2'b10) ? 2'b00 : d[12:11];
      end
      default: ;
    endcase
  endtask

  task automatic model_event(input bit t, input bit m, input bit s, input logic [31:0] c,
                             input logic [31:0] v, input logic [31:0] e,
                             output logic [31:0] pc);
    logic [31:0] dl;
    dl = medeleg;
    pc = 0;
    if (t) begin
      if (m_prv != 2'd3 && dl[c[4:0]]) begin
        m_sepc = e & ~32'd1; m_scause = c; m_stval = v;
        m_spie = m_sie; m_sie = 0; m_spp = m_prv[0]; m_prv = 2'd1;
        pc = stvec & ~32'd3;
      end else begin
        m_mepc = e & ~32'd1; m_mcause = c; m_mtval = v;
        m_mpie = m_mie; m_mie = 0; m_mpp = m_prv; m_prv = 2'd3;
        pc = mtvec & ~32'd3;
      end
    end else if (m) begin
      pc = m_mepc; m_prv = m_mpp; m_mie = m_mpie; m_mpie = 1; m_mpp = 2'd0;
    end else if (s) begin
      pc = m_sepc; m_prv = {1'b0, m_spp}; m_sie = m_spie; m_spie = 1; m_spp = 0;
    end
  endtask

  task automatic check_arch(input string tag);
    check({tag, ".prv"},     {30'b0, prv_cur}, {30'b0, m_prv});
    check({tag, ".mepc"},    mepc,       m_mepc);
    check({tag, ".mcause"},  mcause,     m_mcause);
    check({tag, ".mtval"},   mtval,      m_mtval);
    check({tag, ".sepc"},    sepc,       m_sepc);
    check({tag, ".scause"},  scause,     m_scause);
    check({tag, ".stval"},   stval,      m_stval);
    check({tag, ".mstatus"}, mstatus_tf, exp_mstatus());
  endtask

  task automatic sw_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_we = 1; csr_waddr = a; csr_wdata = d;
    model_write(a, d);
    @(negedge clk);
    csr_we = 0;
    check_arch("sw_write");
  endtask

  // One full event: optional same-cycle CSR write, d flush wait cycles,
  // r redirect backpressure cycles with junk events/writes thrown in.
  task automatic run_event(input bit t, input bit m, input bit s, input logic [31:0] c,
                           input logic [31:0] v, input logic [31:0] e, input bit wr,
                           input logic [11:0] wa, input logic [31:0] wd,
                           input int d, input int r);
    logic [31:0] exp_pc;
    @(negedge clk);
    trap_en = t; mret = m; sret = s; trap_cause = c; trap_val = v; trap_epc = e;
    csr_we = wr; csr_waddr = wa; csr_wdata = wd;
    if (wr) model_write(wa, wd);
    model_event(t, m, s, c, v, e, exp_pc);
    @(negedge clk);
    trap_en = 0; mret = 0; sret = 0; csr_we = 0;
    check("flush_entry", {30'b0, busy, flush_req}, 32'd3);
    for (int i = 0; i < d; i++) begin
      trap_en = 1'($urandom_range(0, 1)); csr_we = 1'($urandom_range(0, 1));
      csr_waddr = 12'h342; csr_wdata = $urandom;
      @(negedge clk);
      trap_en = 0; csr_we = 0;
      check("flush_hold", {31'b0, flush_req}, 32'd1);
    end
    flush_ack = 1;
    @(negedge clk);
    flush_ack = 0;
    check("commit", {29'b0, busy, flush_req, redir_valid}, 32'd4);
    @(negedge clk);
    check("redir_valid", {31'b0, redir_valid}, 32'd1);
    check("redir_pc", redir_pc, exp_pc);
    for (int i = 0; i < r; i++) begin
      trap_en = 1'($urandom_range(0, 1)); mret = 1'($urandom_range(0, 1));
      csr_we = 1'($urandom_range(0, 1)); csr_waddr = 12'h341; csr_wdata = $urandom;
      @(negedge clk);
      trap_en = 0; mret = 0; csr_we = 0;
      check("redir_hold_pc", redir_pc, exp_pc);
      check("redir_hold_v", {31'b0, redir_valid}, 32'd1);
    end
    redir_ready = 1;
    @(negedge clk);
    redir_ready = 0;
    check("idle_after", {30'b0, busy, redir_valid}, 32'd0);
    check_arch("event");
  endtask

  logic [31:0] k;

  initial begin
    rst = 1; trap_en = 0; mret = 0; sret = 0; csr_we = 0; flush_ack = 0; redir_ready = 0;
    trap_cause = 0; trap_val = 0; trap_epc = 0; medeleg = 0; mtvec = 0; stvec = 0;
    csr_waddr = 0; csr_wdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_ctrl", {29'b0, busy, flush_req, redir_valid}, 32'd0);
    check("rst_pc", redir_pc, 32'd0);
    check("rst_mstatus", mstatus_tf, 32'h0000_1800);
    check_arch("reset");

    // Drop to U via mret
    sw_write(12'h300, 32'h0);
    sw_write(12'h341, 32'h0000_1001);
    run_event(0, 1, 0, 0, 0, 32'h40, 0, 0, 0, 0, 0);
    check("to_user", {30'b0, prv_cur}, 32'd0);

    // Exception from U, not delegated
    medeleg = 0; mtvec = 32'h8000_0201; stvec = 32'h8040_0000;
    run_event(1, 0, 0, 32'd2, 32'h13, 32'h8000_0104, 0, 0, 0, 2, 0);
    check("u_exc_mepc", mepc, 32'h8000_0104);
    check("u_exc_pc", redir_pc, 32'h8000_0200);
    check("u_exc_prv", {30'b0, prv_cur}, 32'd3);
    check("u_exc_mpp", {30'b0, mstatus_tf[12:11]}, 32'd0);

    // Delegated ecall from U
    run_event(0, 1, 0, 0, 0, 32'h44, 0, 0, 0, 0, 0);
    sw_write(12'h300, 32'h0000_0002);
    medeleg = 32'h100;
    run_event(1, 0, 0, 32'd8, 32'h0, 32'h8000_2000, 0, 0, 0, 1, 1);
    check("deleg_prv", {30'b0, prv_cur}, 32'd1);
    check("deleg_pc", redir_pc, 32'h8040_0000);
    check("deleg_spie", {30'b0, mstatus_tf[5], mstatus_tf[1]}, 32'd2);

    // Trap from S into M, then mret with MPP=S, MPIE=1
    medeleg = 0;
    sw_write(12'h300, 32'h0000_0008);
    run_event(1, 0, 0, 32'd5, 32'h77, 32'h8000_3000, 0, 0, 0, 0, 0);
    run_event(0, 1, 0, 0, 0, 32'h8000_3004, 0, 0, 0, 0, 2);
    check("mret_prv", {30'b0, prv_cur}, 32'd1);
    check("mret_pc", redir_pc, 32'h8000_3000);
    check("mret_mie", {31'b0, mstatus_tf[3]}, 32'd1);

    // Trap and mret together: trap wins
    run_event(1, 1, 0, 32'd7, 32'h55, 32'h8000_4000, 0, 0, 0, 0, 0);
    check("trap_wins", mcause, 32'd7);

    // Backpressure with ignored events, plus same-cycle write then commit
    run_event(1, 0, 0, 32'd3, 32'h99, 32'h8000_5002, 1, 12'h342, 32'hABCD, 0, 5);
    check("one_update", mcause, 32'd3);

    for (int it = 0; it < 80; it++) begin
      medeleg = $urandom; mtvec = $urandom; stvec = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        sw_write(addrs[$urandom_range(0, 7)], $urandom);
      end else begin
        k = $urandom_range(1, 7);
        run_event(k[0], k[1], k[2], $urandom_range(0, 31), $urandom, $urandom,
                  1'($urandom_range(0, 1)), addrs[$urandom_range(0, 7)], $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 4));
      end
    end

    // Reset while in FLUSH
    @(negedge clk);
    trap_en = 1; trap_cause = 2; trap_epc = 32'h1234;
    @(negedge clk);
    trap_en = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    check("rst_mid_ctrl", {29'b0, busy, flush_req, redir_valid}, 32'd0);
    check_arch("rst_mid");
    run_event(1, 0, 0, 32'd4, 32'h1, 32'h2000, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
